// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - Shared fetch-stage widths, NOP encoding and FSM state encodings.
// ST_ERR exists only when FETCH_MISALIGN_CHK_EN is defined.
package if_fetch_unit_pkg;

  localparam int PC_WIDTH   = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [INST_WIDTH-1:0] NOP_INST   = 32'h0000_0013;
  localparam logic [PC_WIDTH-1:0]   ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [PC_WIDTH-1:0]   PC_STEP    = PC_WIDTH'(4);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_KILL  = 3'd3
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    ST_ERR   = 3'd4
`endif
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, imem req/ready handshake, redirect with stale-fetch kill, hold.
// Optional misaligned-redirect trap state enabled by FETCH_MISALIGN_CHK_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_src,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  pc_write,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ready,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [PC_WIDTH-1:0]   pc_next,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  fetch_misaligned
);

  fetch_state_t          state_q, state_d, redir_state;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   redir_q, redir_d;
  logic [PC_WIDTH-1:0]   redir_tgt, redir_pc, redir_next_pc;
  logic [INST_WIDTH-1:0] inst_q, inst_d;

  // In KILL a same-cycle redirect overrides the parked target.
  assign redir_tgt = (state_q == ST_KILL && !pc_src) ? redir_q : branch_target;
  assign redir_pc  = redir_tgt & ALIGN_MASK;

`ifdef FETCH_MISALIGN_CHK_EN
  logic redir_bad;
  assign redir_bad     = |redir_tgt[1:0];
  assign redir_state   = redir_bad ? ST_ERR : ST_FETCH;
  assign redir_next_pc = redir_bad ? pc_q : redir_pc;
`else
  assign redir_state   = ST_FETCH;
  assign redir_next_pc = redir_pc;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    inst_d  = inst_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          if (pc_src) begin
            state_d = redir_state;
            pc_d    = redir_next_pc;
          end else begin
            inst_d  = imem_rdata;
            state_d = ST_HOLD;
          end
        end else if (pc_src) begin
          // Address must stay stable until the memory answers.
          redir_d = branch_target;
          state_d = ST_KILL;
        end
      end
      ST_HOLD: begin
        if (pc_src) begin
          state_d = redir_state;
          pc_d    = redir_next_pc;
        end else if (pc_write) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_FETCH;
        end
      end
      ST_KILL: begin
        if (imem_ready) begin
          state_d = redir_state;
          pc_d    = redir_next_pc;
        end else if (pc_src) begin
          redir_d = branch_target;
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      ST_ERR: begin
        if (pc_src && !redir_bad) begin
          state_d = ST_FETCH;
          pc_d    = redir_pc;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      inst_q  <= inst_d;
    end
  end

  assign imem_req   = (state_q == ST_FETCH) || (state_q == ST_KILL);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign pc_next    = pc_q + PC_STEP;
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_valid ? inst_q : NOP_INST;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fetch_misaligned = (state_q == ST_ERR);
`else
  assign fetch_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - Self-checking bench for if_fetch_unit with a transaction-level reference model.
// Honours FETCH_MISALIGN_CHK_EN when the design is built with it.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = '0;
  logic        pc_write = 1'b0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_misaligned;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_src(pc_src), .branch_target(branch_target),
    .pc_write(pc_write), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .pc(pc), .pc_next(pc_next),
    .inst(inst), .inst_valid(inst_valid), .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Reference model: what is outstanding, whether it is stale, what is held.
  bit          m_started, m_busy, m_stale, m_held, m_err;
  logic [31:0] m_pc, m_tgt, m_inst;

  task automatic model_reset();
    m_started = 0; m_busy = 0; m_stale = 0; m_held = 0; m_err = 0;
    m_pc = 32'h0; m_tgt = 32'h0; m_inst = 32'h0;
  endtask

  task automatic model_go(input logic [31:0] dest);
    m_held = 0;
    m_stale = 0;
`ifdef FETCH_MISALIGN_CHK_EN
    if (dest[1:0] != 2'b00) begin
      m_err = 1; m_busy = 0;
      return;
    end
`endif
    m_err = 0;
    m_pc = {dest[31:2], 2'b00};
    m_busy = 1;
  endtask

  task automatic model_step(input bit ps, input logic [31:0] tgt, input bit pw, input bit rdy);
    if (!m_started) begin
      m_started = 1; m_busy = 1;
    end else if (m_err) begin
      if (ps && tgt[1:0] == 2'b00) model_go(tgt);
    end else if (m_busy && m_stale) begin
      if (ps) m_tgt = tgt;
      if (rdy) model_go(m_tgt);
    end else if (m_busy) begin
      if (rdy && ps) model_go(tgt);
      else if (rdy) begin
        m_busy = 0; m_held = 1; m_inst = mem_word(m_pc);
      end else if (ps) begin
        m_stale = 1; m_tgt = tgt;
      end
    end else if (m_held) begin
      if (ps) model_go(tgt);
      else if (pw) begin
        m_held = 0; m_pc = m_pc + 32'd4; m_busy = 1;
      end
    end
  endtask

  function automatic logic [130:0] exp_vec();
    return {m_busy, m_pc, m_pc, m_pc + 32'd4, m_held ? m_inst : NOP_INST, m_held, m_err};
  endfunction

  logic [130:0] dut_vec;
  assign dut_vec = {imem_req, imem_addr, pc, pc_next, inst, inst_valid, fetch_misaligned};

  task automatic drive(input bit ps, input logic [31:0] tgt, input bit pw, input bit rdy);
    pc_src = ps; branch_target = tgt; pc_write = pw; imem_ready = rdy;
    @(posedge clk);
    model_step(ps, tgt, pw, rdy);
    @(negedge clk);
  endtask

  task automatic do_reset();
    pc_src = 0; branch_target = '0; pc_write = 0; imem_ready = 0;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1;
    @(negedge clk);
    checks++;
    if ({imem_req, inst_valid, fetch_misaligned} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {imem_req, inst_valid, fetch_misaligned});
    end
    checks++;
    if (inst !== NOP_INST || pc !== 32'h0 || pc_next !== 32'h4) begin
      errors++; $display("FAIL reset_values: got inst %h pc %h pc_next %h expected 00000013 0 4", inst, pc, pc_next);
    end
    reset = 0;
    model_reset();
    drive(0, 0, 0, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_request: got req %b addr %h expected 1 0", imem_req, imem_addr);
    end
    drive(1, 32'h44, 0, 1);
    drive(0, 0, 0, 1);
    #2 reset = 1;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL async_reset: got valid %b pc %h req %b expected 0 0 0", inst_valid, pc, imem_req);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_zero_wait();
    do_reset();
    for (int j = 0; j < 12; j++) begin
      drive(0, 0, 1, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL zero_wait_model cyc %0d: got %h expected %h", j, dut_vec, exp_vec());
      end
      checks++;
      if (j % 2 == 0) begin
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (j / 2))) begin
          errors++; $display("FAIL zero_wait_addr cyc %0d: got req %b addr %h expected 1 %h", j, imem_req, imem_addr, 4 * (j / 2));
        end
      end else begin
        if (inst_valid !== 1'b1 || inst !== mem_word(32'(4 * (j / 2)))) begin
          errors++; $display("FAIL zero_wait_inst cyc %0d: got valid %b inst %h expected 1 %h", j, inst_valid, inst, mem_word(32'(4 * (j / 2))));
        end
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    drive(0, 0, 0, 0);
    drive(1, 32'h10, 0, 1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL wait_hold cyc %0d: got req %b addr %h valid %b expected 1 10 0", k, imem_req, imem_addr, inst_valid);
      end
      if (k < 3) drive(0, 0, 1, 0);
    end
    drive(0, 0, 0, 1);
    checks++;
    if (inst_valid !== 1'b1 || inst !== mem_word(32'h10)) begin
      errors++; $display("FAIL wait_data: got valid %b inst %h expected 1 %h", inst_valid, inst, mem_word(32'h10));
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 0, 0, 0);
    drive(1, 32'h30, 0, 1);
    drive(0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, $urandom, 0, 1'($urandom));
      checks++;
      if (pc !== 32'h30 || inst !== mem_word(32'h30) || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc %0d: got pc %h inst %h valid %b req %b expected 30 %h 1 0", k, pc, inst, inst_valid, imem_req, mem_word(32'h30));
      end
    end
    drive(0, 0, 1, 0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h34) begin
      errors++; $display("FAIL stall_release: got req %b addr %h expected 1 34", imem_req, imem_addr);
    end
  endtask

  task automatic test_kill();
    do_reset();
    drive(0, 0, 0, 0);
    drive(1, 32'h20, 0, 1);
    drive(1, 32'h100, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h20 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL kill_hold cyc %0d: got req %b addr %h valid %b expected 1 20 0", k, imem_req, imem_addr, inst_valid);
      end
      if (k < 2) drive(0, 0, 1, 0);
    end
    drive(0, 0, 1, 1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL kill_retarget: got req %b addr %h valid %b expected 1 100 0", imem_req, imem_addr, inst_valid);
    end
    drive(0, 0, 0, 1);
    checks++;
    if (inst !== mem_word(32'h100)) begin
      errors++; $display("FAIL kill_data: got %h expected %h", inst, mem_word(32'h100));
    end
    drive(0, 0, 1, 0);
    drive(1, 32'h80, 0, 0);
    drive(1, 32'h90, 0, 1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h90) begin
      errors++; $display("FAIL kill_newer_target: got req %b addr %h expected 1 90", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_vs_stall();
    do_reset();
    drive(0, 0, 0, 0);
    drive(1, 32'h40, 0, 1);
    drive(0, 0, 0, 1);
    drive(1, 32'h60, 0, 0);
    checks++;
    if (pc !== 32'h60 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL redirect_in_hold: got pc %h valid %b req %b expected 60 0 1", pc, inst_valid, imem_req);
    end
    drive(1, 32'hFFFF_FFFC, 0, 1);
    drive(0, 0, 0, 1);
    checks++;
    if (pc !== 32'hFFFF_FFFC || pc_next !== 32'h0) begin
      errors++; $display("FAIL wrap_pc_next: got pc %h pc_next %h expected fffffffc 0", pc, pc_next);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL wrap_consume: got pc %h req %b expected 0 1", pc, imem_req);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    drive(0, 0, 0, 0);
    drive(1, 32'h102, 0, 1);
`ifdef FETCH_MISALIGN_CHK_EN
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL misalign_err cyc %0d: got flag %b req %b valid %b expected 1 0 0", k, fetch_misaligned, imem_req, inst_valid);
      end
      drive(k == 1, 32'h106, 1, 1);
    end
    drive(1, 32'h200, 0, 0);
    checks++;
    if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL misalign_exit: got flag %b req %b addr %h expected 0 1 200", fetch_misaligned, imem_req, imem_addr);
    end
`else
    checks++;
    if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL misalign_forced: got flag %b req %b addr %h expected 0 1 100", fetch_misaligned, imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 600; j++) begin
      drive(($urandom % 5) == 0, $urandom, 1'($urandom), ($urandom % 3) != 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_model cyc %0d: got %h expected %h", j, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_kill();
    test_redirect_vs_stall();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
